// File: rtl/board_win_checker.sv
// Tic-tac-toe win/draw evaluator. It scans the nine cells through an external mux,
// then evaluates the eight lines one per cycle and reports the result with a done pulse.
module board_win_checker #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [15:0] CELL_X        = 16'd1,
    parameter logic [15:0] CELL_O        = 16'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] cell_data,
    output logic [3:0]  cell_sel,
    output logic        busy,
    output logic        done,
    output logic [1:0]  winner,
    output logic [3:0]  win_line,
    output logic        draw
);

    localparam int unsigned CW     = 3;
    localparam int unsigned SW     = 4;
    localparam int unsigned LW     = 3;
    localparam int unsigned NCELLS = 9;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] MARKX = 2'b01;
    localparam logic [1:0] MARKO = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EVAL,
        DONE
    } state_t;

    state_t          state;
    logic [1:0]      board [NCELLS];
    logic [CW-1:0]   cnt;
    logic [LW-1:0]   line;
    logic            found;
    logic [LW-1:0]   found_line;
    logic [1:0]      found_who;

    logic [1:0]      code_c;
    logic [SW-1:0]   ia_c;
    logic [SW-1:0]   ib_c;
    logic [SW-1:0]   ic_c;
    logic [1:0]      ca_c;
    logic [1:0]      cb_c;
    logic [1:0]      cc_c;
    logic            line_win_c;
    logic            full_c;

    // Map the raw mux value onto the two-bit board code.
    always_comb begin
        code_c = EMPTY;
        if (cell_data == CELL_X) begin
            code_c = MARKX;
        end else if (cell_data == CELL_O) begin
            code_c = MARKO;
        end
    end

    // Cell triple belonging to the line under evaluation.
    always_comb begin
        ia_c = SW'(0);
        ib_c = SW'(1);
        ic_c = SW'(2);
        case (line)
            LW'(0): begin ia_c = SW'(0); ib_c = SW'(1); ic_c = SW'(2); end
            LW'(1): begin ia_c = SW'(3); ib_c = SW'(4); ic_c = SW'(5); end
            LW'(2): begin ia_c = SW'(6); ib_c = SW'(7); ic_c = SW'(8); end
            LW'(3): begin ia_c = SW'(0); ib_c = SW'(3); ic_c = SW'(6); end
            LW'(4): begin ia_c = SW'(1); ib_c = SW'(4); ic_c = SW'(7); end
            LW'(5): begin ia_c = SW'(2); ib_c = SW'(5); ic_c = SW'(8); end
            LW'(6): begin ia_c = SW'(0); ib_c = SW'(4); ic_c = SW'(8); end
            default: begin ia_c = SW'(2); ib_c = SW'(4); ic_c = SW'(6); end
        endcase
    end

    assign ca_c       = board[ia_c];
    assign cb_c       = board[ib_c];
    assign cc_c       = board[ic_c];
    assign line_win_c = (ca_c != EMPTY) && (ca_c == cb_c) && (cb_c == cc_c);

    always_comb begin
        full_c = 1'b1;
        for (int i = 0; i < int'(NCELLS); i++) begin
            if (board[i] == EMPTY) begin
                full_c = 1'b0;
            end
        end
    end

    // cell_sel doubles as the scan index; it is forced back to 0 outside SCAN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= CW'(0);
            line       <= LW'(0);
            found      <= 1'b0;
            found_line <= LW'(0);
            found_who  <= EMPTY;
            cell_sel   <= SW'(0);
            busy       <= 1'b0;
            done       <= 1'b0;
            winner     <= 2'b00;
            win_line   <= 4'hF;
            draw       <= 1'b0;
            for (int i = 0; i < int'(NCELLS); i++) begin
                board[i] <= EMPTY;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cell_sel <= SW'(0);
                    if (start) begin
                        state    <= SCAN;
                        cnt      <= CW'(0);
                        found    <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SCAN: begin
                    if (cnt == CW'(SETTLE_CYCLES)) begin
                        board[cell_sel] <= code_c;
                        cnt             <= CW'(0);
                        if (cell_sel == SW'(NCELLS - 1)) begin
                            cell_sel <= SW'(0);
                            line     <= LW'(0);
                            state    <= EVAL;
                        end else begin
                            cell_sel <= cell_sel + SW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                EVAL: begin
                    // Only the first winning line in evaluation order is kept.
                    if (line_win_c && !found) begin
                        found      <= 1'b1;
                        found_line <= line;
                        found_who  <= ca_c;
                    end
                    if (line == LW'(7)) begin
                        state <= DONE;
                    end else begin
                        line <= line + LW'(1);
                    end
                end
                DONE: begin
                    winner   <= found ? found_who : 2'b00;
                    win_line <= found ? {1'b0, found_line} : 4'hF;
                    draw     <= !found && full_c;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_win_checker.sv
// Bench for board_win_checker: a line-table model predicts every output each cycle,
// and directed boards carry hand-computed results and latency.
module tb_board_win_checker;

    localparam int S   = 1;
    localparam int LAT = 9 * (S + 1) + 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cell_data;
    logic [3:0]  cell_sel;
    logic        busy;
    logic        done;
    logic [1:0]  winner;
    logic [3:0]  win_line;
    logic        draw;

    logic [15:0] mem [9];

    int errors = 0;
    int checks = 0;

    board_win_checker #(
        .SETTLE_CYCLES(S),
        .CELL_X(16'd1),
        .CELL_O(16'd2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cell_data(cell_data),
        .cell_sel(cell_sel),
        .busy(busy),
        .done(done),
        .winner(winner),
        .win_line(win_line),
        .draw(draw)
    );

    always #5 clk = ~clk;

    // The bench plays the role of the 9-way cell mux.
    assign cell_data = (cell_sel <= 4'd8) ? mem[cell_sel] : 16'hDEAD;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the winning lines as a plain table.
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic int mark(input logic [15:0] v);
        if (v == 16'd1) return 1;
        if (v == 16'd2) return 2;
        return 0;
    endfunction

    int p_w, p_l, p_d;

    task automatic predict();
        int a, b, c, empties;
        p_w = 0; p_l = 15; p_d = 0; empties = 0;
        for (int k = 0; k < 8; k++) begin
            a = mark(mem[lines[k][0]]);
            b = mark(mem[lines[k][1]]);
            c = mark(mem[lines[k][2]]);
            if (p_w == 0 && a != 0 && a == b && b == c) begin
                p_w = a;
                p_l = k;
            end
        end
        for (int k = 0; k < 9; k++) if (mark(mem[k]) == 0) empties++;
        if (p_w == 0 && empties == 0) p_d = 1;
    endtask

    bit armed  = 1'b0;
    bit active = 1'b0;
    int t      = 0;
    int e_sel = 0, e_busy = 0, e_done = 0, e_w = 0, e_l = 15, e_d = 0;

    always @(posedge clk) begin
        if (rst) begin
            active = 1'b0; t = 0;
            e_sel = 0; e_busy = 0; e_done = 0; e_w = 0; e_l = 15; e_d = 0;
            armed = 1'b1;
        end else begin
            e_done = 0;
            if (active) begin
                t++;
                if (t == LAT) begin
                    active = 1'b0;
                    e_busy = 0; e_done = 1;
                    e_w = p_w; e_l = p_l; e_d = p_d;
                end
            end else if (start) begin
                active = 1'b1; t = 0; e_busy = 1;
                predict();
            end
            e_sel = (active && t < 9 * (S + 1)) ? t / (S + 1) : 0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("cell_sel", int'(cell_sel), e_sel);
            check("busy", int'(busy), e_busy);
            check("done", int'(done), e_done);
            check("winner", int'(winner), e_w);
            check("win_line", int'(win_line), e_l);
            check("draw", int'(draw), e_d);
        end
    end

    task automatic set_board(input int c0, c1, c2, c3, c4, c5, c6, c7, c8);
        mem[0] = 16'(c0); mem[1] = 16'(c1); mem[2] = 16'(c2);
        mem[3] = 16'(c3); mem[4] = 16'(c4); mem[5] = 16'(c5);
        mem[6] = 16'(c6); mem[7] = 16'(c7); mem[8] = 16'(c8);
    endtask

    // Pulse start, optionally re-pulse it at clock 'extra', and pin the literal result.
    task automatic do_scan(input string name, input int extra,
                           input int ew, input int el, input int ed);
        int n;
        bit seen;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 60) begin
            @(posedge clk);
            n++;
            #1;
            start = (n == extra) ? 1'b1 : 1'b0;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({name, "_latency"}, seen ? n : -1, 27);
        check({name, "_winner"}, int'(winner), ew);
        check({name, "_line"}, int'(win_line), el);
        check({name, "_draw"}, int'(draw), ed);
        @(posedge clk); #1;
        check({name, "_done_pulse"}, int'(done), 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        set_board(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_sel", int'(cell_sel), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_line", int'(win_line), 15);
        check("reset_winner", int'(winner), 0);

        do_scan("empty", -1, 0, 15, 0);

        set_board(1, 1, 1, 2, 2, 0, 0, 0, 0);
        do_scan("xrow0", -1, 1, 0, 0);

        set_board(1, 1, 2, 1, 2, 0, 2, 0, 0);
        do_scan("odiag", -1, 2, 7, 0);

        set_board(1, 2, 1, 1, 2, 2, 2, 1, 1);
        do_scan("draw", -1, 0, 15, 1);

        mem[8] = 16'd3;
        do_scan("nodraw", -1, 0, 15, 0);

        set_board(1, 1, 1, 0, 0, 0, 2, 2, 2);
        do_scan("illegal", 5, 1, 0, 0);

        // Abort mid-scan; a start coincident with rst must be dropped.
        set_board(2, 0, 0, 2, 0, 0, 2, 0, 0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1; start = 1'b1;
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        check("abort_sel", int'(cell_sel), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_winner", int'(winner), 0);
        check("abort_line", int'(win_line), 15);
        @(posedge clk); #1;
        check("abort_idle", int'(busy), 0);

        do_scan("after_abort", -1, 2, 3, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
